// File: rtl/l2_bus_pkg.sv
// rtl/l2_bus_pkg.sv - shared types and constants for the L2 bus arbiter
package l2_bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int NUM_REQ  = 2;
    localparam int L2_BEATS = 4;

endpackage

// File: rtl/l2_bus_arbiter_if.sv
// rtl/l2_bus_arbiter_if.sv - requester and L2 memory signal bundle for the arbiter
interface l2_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [l2_bus_pkg::NUM_REQ-1:0]             req_rd_en;
    logic [l2_bus_pkg::NUM_REQ-1:0]             req_wr_en;
    logic [l2_bus_pkg::NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [l2_bus_pkg::NUM_REQ-1:0][DATA_W-1:0] req_wr_data;
    logic [l2_bus_pkg::NUM_REQ-1:0]             rd_granted;
    logic [l2_bus_pkg::NUM_REQ-1:0]             wr_granted;
    logic [DATA_W-1:0]                          l2_rd_data;
    logic [ADDR_W-1:0]                          mem_addr;
    logic                                       mem_rd_en;
    logic                                       mem_wr_en;
    logic [DATA_W-1:0]                          mem_wr_data;
    logic [DATA_W-1:0]                          mem_rd_data;
    logic                                       mem_ack;

    // master is the arbiter side, slave is the requester/L2 environment
    modport master (
        input  req_rd_en, req_wr_en, req_addr, req_wr_data, mem_rd_data, mem_ack,
        output rd_granted, wr_granted, l2_rd_data, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
    );

    modport slave (
        output req_rd_en, req_wr_en, req_addr, req_wr_data, mem_rd_data, mem_ack,
        input  rd_granted, wr_granted, l2_rd_data, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
    );
endinterface

// File: rtl/l2_bus_arbiter_rr_picker_2.sv
// rtl/l2_bus_arbiter_rr_picker_2.sv - combinational 2-way round-robin selector
module rr_picker_2 (
    input  logic [1:0] req,
    input  logic [0:0] last,
    output logic       gnt_idx,
    output logic       any
);
    always_comb begin
        any     = |req;
        gnt_idx = 1'b0;
        // On a tie the requester that did not own the bus last wins
        if (req == 2'b11) begin
            gnt_idx = ~last[0];
        end else if (req[1]) begin
            gnt_idx = 1'b1;
        end
    end
endmodule

// File: rtl/l2_bus_arbiter.sv
// rtl/l2_bus_arbiter.sv - round-robin owner arbiter for the single L2 port
// Optional hold watchdog and arb_timeout port: define L2_ARB_WATCHDOG_EN.
module l2_bus_arbiter
    import l2_bus_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int HOLD_MAX = 64
) (
    input  logic                clk,
    input  logic                rst,
    l2_bus_arbiter_if.master    bus,
    output logic                owner,
    output logic                bus_busy
`ifdef L2_ARB_WATCHDOG_EN
    ,
    output logic                arb_timeout
`endif
);
    arb_state_t state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;

    logic [NUM_REQ-1:0] active;
    logic               pick_idx;
    logic               pick_any;
    logic               own_rd;
    logic               own_wr;

    logic               rd_en;
    logic               wr_en;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic [DATA_W-1:0]  rdata;
    logic [NUM_REQ-1:0] rd_g;
    logic [NUM_REQ-1:0] wr_g;

`ifdef L2_ARB_WATCHDOG_EN
    localparam int HOLD_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;
    logic              hold_expired;

    assign hold_expired = (hold_q == HOLD_W'(HOLD_MAX - 1));
`endif

    assign active = bus.req_rd_en | bus.req_wr_en;
    assign own_rd = bus.req_rd_en[owner_q];
    assign own_wr = bus.req_wr_en[owner_q];

    rr_picker_2 u_picker (
        .req     (active),
        .last    (last_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        addr    = '0;
        wdata   = '0;
        rdata   = '0;
        rd_g    = '0;
        wr_g    = '0;
`ifdef L2_ARB_WATCHDOG_EN
        hold_d    = hold_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = BUSY;
                    owner_d = pick_idx;
`ifdef L2_ARB_WATCHDOG_EN
                    hold_d  = '0;
`endif
                end
            end
            BUSY: begin
                // The refill read must finish before the write-through word goes out
                rd_en         = own_rd;
                wr_en         = own_wr & ~own_rd;
                addr          = bus.req_addr[owner_q];
                wdata         = bus.req_wr_data[owner_q];
                rdata         = bus.mem_rd_data;
                rd_g[owner_q] = bus.mem_ack & rd_en;
                wr_g[owner_q] = bus.mem_ack & wr_en;
                if (!own_rd && !own_wr) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
`ifdef L2_ARB_WATCHDOG_EN
                else if (hold_expired) begin
                    state_d   = IDLE;
                    last_d    = owner_q;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
`ifdef L2_ARB_WATCHDOG_EN
            hold_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
`ifdef L2_ARB_WATCHDOG_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign bus.mem_rd_en   = rd_en;
    assign bus.mem_wr_en   = wr_en;
    assign bus.mem_addr    = addr;
    assign bus.mem_wr_data = wdata;
    assign bus.l2_rd_data  = rdata;
    assign bus.rd_granted  = rd_g;
    assign bus.wr_granted  = wr_g;
    assign owner           = owner_q;
    assign bus_busy        = (state_q == BUSY);
`ifdef L2_ARB_WATCHDOG_EN
    assign arb_timeout     = timeout_q;
`endif

endmodule

// File: tb/tb_l2_bus_arbiter.sv
// tb/tb_l2_bus_arbiter.sv - randomized and directed self-checking bench for l2_bus_arbiter
module tb_l2_bus_arbiter;
    localparam int HOLD_MAX = 8;
    localparam int BEATS    = l2_bus_pkg::L2_BEATS;

    logic clk;
    logic rst;
    logic owner;
    logic bus_busy;
`ifdef L2_ARB_WATCHDOG_EN
    logic arb_timeout;
`endif

    int checks = 0;
    int errors = 0;

    l2_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    l2_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .HOLD_MAX(HOLD_MAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .owner       (owner),
        .bus_busy    (bus_busy)
`ifdef L2_ARB_WATCHDOG_EN
        ,
        .arb_timeout (arb_timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who owns the bus, who owned it last, how long it has been held
    bit          m_busy;
    bit          m_owner;
    bit          m_last;
    bit          m_timeout;
    int          m_hold;
    logic        e_rd, e_wr;
    logic [31:0] e_addr, e_wdata, e_l2;
    logic [1:0]  e_rdg, e_wrg;

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_last = 1; m_timeout = 0; m_hold = 0;
    endtask

    task automatic model_eval();
        e_rd = 0; e_wr = 0; e_addr = 0; e_wdata = 0; e_l2 = 0; e_rdg = 0; e_wrg = 0;
        if (m_busy) begin
            e_rd           = bus.req_rd_en[m_owner];
            e_wr           = bus.req_wr_en[m_owner] && !e_rd;
            e_addr         = bus.req_addr[m_owner];
            e_wdata        = bus.req_wr_data[m_owner];
            e_l2           = bus.mem_rd_data;
            e_rdg[m_owner] = bus.mem_ack && e_rd;
            e_wrg[m_owner] = bus.mem_ack && e_wr;
        end
    endtask

    task automatic model_update();
        logic [1:0] act;
        act = bus.req_rd_en | bus.req_wr_en;
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (act != 2'b00) begin
                m_busy  = 1;
                m_hold  = 0;
                m_owner = (act == 2'b11) ? !m_last : act[1];
            end
        end else if (!bus.req_rd_en[m_owner] && !bus.req_wr_en[m_owner]) begin
            m_busy = 0;
            m_last = m_owner;
        end
`ifdef L2_ARB_WATCHDOG_EN
        else if (m_hold == HOLD_MAX - 1) begin
            m_busy    = 0;
            m_last    = m_owner;
            m_timeout = 1;
        end
`endif
        else begin
            m_hold++;
        end
    endtask

    task automatic settle();
        #2;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_rd_en   = 2'b00;
        bus.req_wr_en   = 2'b00;
        bus.req_addr    = '0;
        bus.req_wr_data = '0;
        bus.mem_rd_data = '0;
        bus.mem_ack     = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        settle();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.mem_rd_data = 32'h5A5A_5A5A;
        bus.mem_ack     = 1'b1;
        rst = 1'b1;
        settle(); tick(); settle(); tick();
        rst = 1'b0;
        settle();
        checks++; if ({bus.mem_rd_en, bus.mem_wr_en} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {bus.mem_rd_en, bus.mem_wr_en}); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", bus.mem_addr); end
        checks++; if (bus.mem_wr_data !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", bus.mem_wr_data); end
        checks++; if ({bus.rd_granted, bus.wr_granted} !== 4'b0) begin errors++; $display("FAIL reset_grants: got %b expected 0000", {bus.rd_granted, bus.wr_granted}); end
        checks++; if (bus.l2_rd_data !== 32'h0) begin errors++; $display("FAIL reset_l2_rd_data: got %h expected 0", bus.l2_rd_data); end
        checks++; if ({owner, bus_busy} !== 2'b00) begin errors++; $display("FAIL reset_owner_busy: got %b expected 00", {owner, bus_busy}); end
        tick();
    endtask

    task automatic test_single_read();
        int  beats = 0;
        bit  r1_seen = 0;
        clear_inputs();
        bus.req_addr[0] = 32'h0000_1230;
        bus.req_rd_en   = 2'b01;
        for (int cyc = 0; cyc < 40 && beats < BEATS; cyc++) begin
            bus.mem_ack     = cyc[0];
            bus.mem_rd_data = 32'hA0 + beats;
            settle();
            if (cyc == 0) begin
                checks++; if (bus.mem_rd_en !== 1'b0) begin errors++; $display("FAIL single_arb_idle: got %b expected 0", bus.mem_rd_en); end
            end
            if (cyc == 1) begin
                checks++; if ({bus.mem_rd_en, bus.mem_addr} !== {1'b1, 32'h0000_1230}) begin errors++; $display("FAIL single_first_strobe: got %b/%h expected 1/00001230", bus.mem_rd_en, bus.mem_addr); end
            end
            checks++; if (bus.rd_granted !== e_rdg) begin errors++; $display("FAIL single_rd_granted: got %b expected %b", bus.rd_granted, e_rdg); end
            if (bus.rd_granted[1]) r1_seen = 1;
            if (bus.rd_granted[0]) begin
                checks++; if (bus.l2_rd_data !== 32'hA0 + beats) begin errors++; $display("FAIL single_data: got %h expected %h", bus.l2_rd_data, 32'hA0 + beats); end
                beats++;
            end
            tick();
        end
        checks++; if (beats != BEATS) begin errors++; $display("FAIL single_beats: got %0d expected %0d", beats, BEATS); end
        checks++; if (r1_seen) begin errors++; $display("FAIL single_rd_granted1: got 1 expected 0"); end
        bus.req_rd_en = 2'b00;
        bus.mem_ack   = 1'b0;
        settle();
        checks++; if (bus_busy !== 1'b1) begin errors++; $display("FAIL single_busy_hold: got %b expected 1", bus_busy); end
        tick();
        settle();
        checks++; if (bus_busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b expected 0", bus_busy); end
        tick();
    endtask

    task automatic test_round_robin();
        int ten_owner[$];
        int gaps[$];
        int beats[2];
        bit down[2];
        int done = 0;
        int last_grant = 0;
        int g;
        beats = '{0, 0};
        down  = '{0, 0};
        pulse_reset();
        clear_inputs();
        bus.req_addr[0] = 32'h100;
        bus.req_addr[1] = 32'h200;
        bus.req_rd_en   = 2'b11;
        bus.mem_ack     = 1'b1;
        for (int cyc = 0; cyc < 120 && done < 4; cyc++) begin
            bus.mem_rd_data = $urandom;
            settle();
            checks++; if (bus.rd_granted !== e_rdg) begin errors++; $display("FAIL rr_rd_granted: got %b expected %b", bus.rd_granted, e_rdg); end
            checks++; if ({owner, bus_busy} !== {m_owner, m_busy}) begin errors++; $display("FAIL rr_owner_busy: got %b expected %b", {owner, bus_busy}, {m_owner, m_busy}); end
            if (bus.rd_granted != 2'b00) begin
                g = bus.rd_granted[1] ? 1 : 0;
                if (beats[g] == 0) begin
                    if (ten_owner.size() > 0) gaps.push_back(cyc - last_grant);
                    ten_owner.push_back(g);
                end
                beats[g]++;
                last_grant = cyc;
            end
            tick();
            for (int i = 0; i < 2; i++) begin
                if (down[i]) begin
                    down[i] = 0;
                    bus.req_rd_en[i] = 1'b1;
                end else if (beats[i] == BEATS) begin
                    beats[i] = 0;
                    down[i]  = 1;
                    bus.req_rd_en[i] = 1'b0;
                    done++;
                end
            end
        end
        checks++; if (ten_owner.size() < 4) begin errors++; $display("FAIL rr_tenures: got %0d expected 4", ten_owner.size()); end
        for (int i = 0; i < 4 && i < ten_owner.size(); i++) begin
            checks++; if (ten_owner[i] != i % 2) begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, ten_owner[i], i % 2); end
        end
        foreach (gaps[i]) begin
            checks++; if (gaps[i] != 3) begin errors++; $display("FAIL rr_turnaround[%0d]: got %0d expected 3", i, gaps[i]); end
        end
        clear_inputs();
        settle(); tick(); settle(); tick();
    endtask

    task automatic test_write_after_refill();
        int nrd = 0;
        clear_inputs();
        bus.req_addr[1]    = 32'h0000_4000;
        bus.req_wr_data[1] = 32'hDEAD_BEEF;
        bus.req_rd_en      = 2'b10;
        bus.req_wr_en      = 2'b10;
        bus.mem_ack        = 1'b1;
        for (int cyc = 0; cyc < 20 && nrd < BEATS; cyc++) begin
            bus.mem_rd_data = $urandom;
            settle();
            checks++; if (bus.mem_wr_en !== 1'b0) begin errors++; $display("FAIL war_wr_blocked: got %b expected 0", bus.mem_wr_en); end
            if (bus.rd_granted[1]) nrd++;
            tick();
        end
        checks++; if (nrd != BEATS) begin errors++; $display("FAIL war_reads: got %0d expected %0d", nrd, BEATS); end
        bus.req_rd_en = 2'b00;
        settle();
        checks++; if ({bus.mem_wr_en, bus.mem_wr_data} !== {1'b1, 32'hDEAD_BEEF}) begin errors++; $display("FAIL war_write: got %b/%h expected 1/deadbeef", bus.mem_wr_en, bus.mem_wr_data); end
        checks++; if (bus.wr_granted !== 2'b10) begin errors++; $display("FAIL war_wr_granted: got %b expected 10", bus.wr_granted); end
        tick();
        bus.req_wr_en = 2'b00;
        settle();
        checks++; if (bus.wr_granted !== 2'b00) begin errors++; $display("FAIL war_wr_release: got %b expected 00", bus.wr_granted); end
        tick();
        clear_inputs();
        settle(); tick();
    endtask

    task automatic test_isolation();
        clear_inputs();
        bus.req_addr[0]    = 32'h0000_0800;
        bus.req_wr_data[0] = 32'h1111_2222;
        bus.req_rd_en      = 2'b01;
        for (int cyc = 0; cyc < 20; cyc++) begin
            bus.req_addr[1]    = $urandom | 32'h8000_0000;
            bus.req_wr_data[1] = $urandom | 32'h8000_0000;
            bus.mem_ack        = ($urandom_range(0, 2) == 0);
            settle();
            if (bus_busy) begin
                checks++; if ({bus.mem_addr, bus.mem_wr_data} !== {32'h0000_0800, 32'h1111_2222}) begin errors++; $display("FAIL iso_mux: got %h/%h expected 00000800/11112222", bus.mem_addr, bus.mem_wr_data); end
            end
            tick();
        end
        clear_inputs();
        settle(); tick(); settle(); tick();
    endtask

    task automatic test_reset_mid_beat();
        bit got = 0;
        clear_inputs();
        bus.req_addr[0] = 32'h0000_2000;
        bus.req_rd_en   = 2'b01;
        bus.mem_ack     = 1'b1;
        for (int cyc = 0; cyc < 6 && !got; cyc++) begin
            settle();
            got = bus.rd_granted[0];
            tick();
        end
        checks++; if (!got) begin errors++; $display("FAIL rmb_first_beat: got 0 expected 1"); end
        bus.mem_ack = 1'b0;
        rst = 1'b1;
        settle();
        tick();
        rst = 1'b0;
        bus.mem_ack     = 1'b1;
        bus.mem_rd_data = 32'hCAFE_F00D;
        settle();
        checks++; if ({bus.mem_rd_en, bus.mem_wr_en, bus.rd_granted, bus.wr_granted} !== 6'b0) begin errors++; $display("FAIL rmb_strobes_grants: got %b expected 000000", {bus.mem_rd_en, bus.mem_wr_en, bus.rd_granted, bus.wr_granted}); end
        checks++; if ({bus.mem_addr, bus.l2_rd_data} !== 64'h0) begin errors++; $display("FAIL rmb_addr_data: got %h/%h expected 0/0", bus.mem_addr, bus.l2_rd_data); end
        checks++; if ({owner, bus_busy} !== 2'b00) begin errors++; $display("FAIL rmb_owner_busy: got %b expected 00", {owner, bus_busy}); end
        tick();
        clear_inputs();
        settle(); tick(); settle(); tick();
    endtask

`ifdef L2_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        int held = 0;
        bit saw1 = 0;
        pulse_reset();
        clear_inputs();
        bus.req_rd_en = 2'b11;
        for (int cyc = 0; cyc < 30 && !saw1; cyc++) begin
            settle();
            if (bus_busy && owner == 1'b0) held++;
            if (bus_busy && owner == 1'b1) saw1 = 1;
            if (!saw1) tick();
        end
        checks++; if (held != HOLD_MAX) begin errors++; $display("FAIL wd_hold_cycles: got %0d expected %0d", held, HOLD_MAX); end
        checks++; if (arb_timeout !== 1'b1) begin errors++; $display("FAIL wd_timeout: got %b expected 1", arb_timeout); end
        checks++; if (!saw1) begin errors++; $display("FAIL wd_handoff: got 0 expected 1"); end
        tick();
        clear_inputs();
        settle(); tick(); settle(); tick();
        checks++; if (arb_timeout !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %b expected 1", arb_timeout); end
        pulse_reset();
        settle();
        checks++; if (arb_timeout !== 1'b0) begin errors++; $display("FAIL wd_clear: got %b expected 0", arb_timeout); end
        tick();
    endtask
`endif

    task automatic test_random();
        clear_inputs();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0: bus.req_rd_en[0] = ~bus.req_rd_en[0];
                    1: bus.req_rd_en[1] = ~bus.req_rd_en[1];
                    2: bus.req_wr_en[0] = ~bus.req_wr_en[0];
                    default: bus.req_wr_en[1] = ~bus.req_wr_en[1];
                endcase
            end
            bus.req_addr[0]    = $urandom;
            bus.req_addr[1]    = $urandom;
            bus.req_wr_data[0] = $urandom;
            bus.req_wr_data[1] = $urandom;
            bus.mem_rd_data    = $urandom;
            bus.mem_ack        = $urandom_range(0, 1);
            rst                = ($urandom_range(0, 149) == 0);
            settle();
            checks++; if ({bus.mem_rd_en, bus.mem_wr_en} !== {e_rd, e_wr}) begin errors++; $display("FAIL rnd_strobes @%0d: got %b expected %b", cyc, {bus.mem_rd_en, bus.mem_wr_en}, {e_rd, e_wr}); end
            checks++; if (bus.mem_addr !== e_addr) begin errors++; $display("FAIL rnd_addr @%0d: got %h expected %h", cyc, bus.mem_addr, e_addr); end
            checks++; if (bus.mem_wr_data !== e_wdata) begin errors++; $display("FAIL rnd_wdata @%0d: got %h expected %h", cyc, bus.mem_wr_data, e_wdata); end
            checks++; if (bus.l2_rd_data !== e_l2) begin errors++; $display("FAIL rnd_l2_rd_data @%0d: got %h expected %h", cyc, bus.l2_rd_data, e_l2); end
            checks++; if ({bus.rd_granted, bus.wr_granted} !== {e_rdg, e_wrg}) begin errors++; $display("FAIL rnd_grants @%0d: got %b expected %b", cyc, {bus.rd_granted, bus.wr_granted}, {e_rdg, e_wrg}); end
            checks++; if ({owner, bus_busy} !== {m_owner, m_busy}) begin errors++; $display("FAIL rnd_owner_busy @%0d: got %b expected %b", cyc, {owner, bus_busy}, {m_owner, m_busy}); end
`ifdef L2_ARB_WATCHDOG_EN
            checks++; if (arb_timeout !== m_timeout) begin errors++; $display("FAIL rnd_timeout @%0d: got %b expected %b", cyc, arb_timeout, m_timeout); end
`endif
            tick();
        end
        rst = 1'b0;
        clear_inputs();
        settle(); tick();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();
        #1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_after_refill();
        test_isolation();
        test_reset_mid_beat();
`ifdef L2_ARB_WATCHDOG_EN
        test_watchdog();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
